// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon permutation engine and its round datapath.
package ascon_pkg;

  localparam int LANE_W = 64;

  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    lane_t x0;
    lane_t x1;
    lane_t x2;
    lane_t x3;
    lane_t x4;
  } ascon_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [3:0] P12 = 4'd12;
  localparam logic [3:0] P8  = 4'd8;
  localparam logic [3:0] P6  = 4'd6;

  localparam lane_t HASH_IV = 64'h00400c0000000100;

  // rcon is the number of rounds still to go, so round index i = 12 - rcon
  // and the constant is {15-i, i}: 12 -> 0xf0, 8 -> 0xb4, 6 -> 0x96, 1 -> 0x4b.
  function automatic logic [7:0] round_const(input logic [3:0] rcon);
    return {4'(rcon + 4'd3), 4'(4'd12 - rcon)};
  endfunction

endpackage

// File: rtl/ascon_perm_ctrl_if.sv
// Request/response bundle between the sponge controller (master) and the permutation engine (slave).
interface ascon_perm_ctrl_if
  import ascon_pkg::*;
();

  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_rounds;
  lane_t      x0_in, x1_in, x2_in, x3_in, x4_in;
  logic       out_valid;
  logic       out_ready;
  lane_t      x0_out, x1_out, x2_out, x3_out, x4_out;

  modport master (
    output in_valid, in_rounds, x0_in, x1_in, x2_in, x3_in, x4_in, out_ready,
    input  in_ready, out_valid, x0_out, x1_out, x2_out, x3_out, x4_out
  );

  modport slave (
    input  in_valid, in_rounds, x0_in, x1_in, x2_in, x3_in, x4_in, out_ready,
    output in_ready, out_valid, x0_out, x1_out, x2_out, x3_out, x4_out
  );

endinterface

// File: rtl/asconp.sv
// One combinational Ascon round: constant addition, bitsliced 5-bit S-box, linear diffusion.
module asconp
  import ascon_pkg::*;
(
  input  logic [3:0] rcon,
  input  lane_t      x0_i,
  input  lane_t      x1_i,
  input  lane_t      x2_i,
  input  lane_t      x3_i,
  input  lane_t      x4_i,
  output lane_t      x0_o,
  output lane_t      x1_o,
  output lane_t      x2_o,
  output lane_t      x3_o,
  output lane_t      x4_o
);

  function automatic lane_t ror(input lane_t v, input int unsigned k);
    return (v >> k) | (v << (LANE_W - k));
  endfunction

  lane_t c2;
  lane_t a0, a1, a2, a3, a4;
  lane_t b0, b1, b2, b3, b4;
  lane_t s0, s1, s2, s3, s4;

  assign c2 = x2_i ^ {56'h0, round_const(rcon)};

  assign a0 = x0_i ^ x4_i;
  assign a1 = x1_i;
  assign a2 = c2 ^ x1_i;
  assign a3 = x3_i;
  assign a4 = x4_i ^ x3_i;

  // Chi-like core of the S-box
  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  assign s0 = b0 ^ b4;
  assign s1 = b1 ^ b0;
  assign s2 = ~b2;
  assign s3 = b3 ^ b2;
  assign s4 = b4;

  assign x0_o = s0 ^ ror(s0, 19) ^ ror(s0, 28);
  assign x1_o = s1 ^ ror(s1, 61) ^ ror(s1, 39);
  assign x2_o = s2 ^ ror(s2, 1)  ^ ror(s2, 6);
  assign x3_o = s3 ^ ror(s3, 10) ^ ror(s3, 17);
  assign x4_o = s4 ^ ror(s4, 7)  ^ ror(s4, 41);

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Iterative Ascon permutation: runs 1..MAX_ROUNDS rounds over a registered state,
// UNROLL (1 or 2) rounds per clock, between valid/ready request and result handshakes.
module ascon_perm_ctrl
  import ascon_pkg::*;
#(
  parameter int UNROLL     = 1,
  parameter int MAX_ROUNDS = 12
) (
  input  logic               clock,
  input  logic               reset_n,
  ascon_perm_ctrl_if.slave   bus,
  output logic               busy
);

  if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
    $error("ascon_perm_ctrl: UNROLL must be 1 or 2");
  end

  localparam logic [3:0] CAP = 4'(MAX_ROUNDS);

  fsm_t         fsm_q;
  ascon_state_t st_q;
  logic [3:0]   cnt_q;
  logic         out_valid_q;
  logic         busy_q;

  ascon_state_t rnd [UNROLL+1];
  ascon_state_t req_st;
  ascon_state_t nxt_st;
  logic [3:0]   n_req;
  logic [3:0]   step;
  logic         accept;

  assign rnd[0] = st_q;

  // Instance i applies the round whose remaining-count is cnt_q - i.
  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    lane_t y0, y1, y2, y3, y4;

    asconp u_round (
      .rcon (cnt_q - 4'(i)),
      .x0_i (rnd[i].x0),
      .x1_i (rnd[i].x1),
      .x2_i (rnd[i].x2),
      .x3_i (rnd[i].x3),
      .x4_i (rnd[i].x4),
      .x0_o (y0),
      .x1_o (y1),
      .x2_o (y2),
      .x3_o (y3),
      .x4_o (y4)
    );

    assign rnd[i+1] = {y0, y1, y2, y3, y4};
  end

  // A lone final round on the two-round datapath skips the second instance.
  assign step   = ((UNROLL == 2) && (cnt_q == 4'd1)) ? 4'd1 : 4'(UNROLL);
  assign nxt_st = ((UNROLL == 2) && (cnt_q == 4'd1)) ? rnd[1] : rnd[UNROLL];

  assign n_req  = (bus.in_rounds > CAP) ? CAP : bus.in_rounds;
  assign req_st = {bus.x0_in, bus.x1_in, bus.x2_in, bus.x3_in, bus.x4_in};

  assign bus.in_ready = (fsm_q == IDLE) | ((fsm_q == DONE) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= IDLE;
      st_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept) begin
      st_q  <= req_st;
      cnt_q <= n_req;
      if (n_req != 4'd0) begin
        fsm_q       <= RUN;
        busy_q      <= 1'b1;
        out_valid_q <= 1'b0;
      end else begin
        fsm_q       <= DONE;
        busy_q      <= 1'b0;
        out_valid_q <= 1'b1;
      end
    end else begin
      unique case (fsm_q)
        RUN: begin
          st_q  <= nxt_st;
          cnt_q <= cnt_q - step;
          if (cnt_q == step) begin
            fsm_q       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        IDLE: ;
        default: begin
          fsm_q       <= IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.x0_out    = st_q.x0;
  assign bus.x1_out    = st_q.x1;
  assign bus.x2_out    = st_q.x2;
  assign bus.x3_out    = st_q.x3;
  assign bus.x4_out    = st_q.x4;
  assign busy          = busy_q;

endmodule

// File: doc/ascon_perm_ctrl.md
Name: ascon_perm_ctrl

Overview:
Iterative Ascon permutation engine. Sequences the existing combinational round module asconp over a registered 320-bit state, applying 1..12 rounds per request with the correct round-constant schedule. Sits between the Ascon mode/sponge controller (absorb/squeeze logic) and the round datapath, using valid/ready handshakes on both sides.

Parameters:
UNROLL, 1, rounds per clock: 1 or 2 (two asconp instances chained); other values are illegal (elaboration error).
MAX_ROUNDS, 12, rounds cap; in_rounds above this is clamped.

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  request present
in_ready  output  1  engine can accept request
in_rounds  input  4  rounds to apply (12=p12, 8=p8, 6=p6; 0=pass-through)
x0_in..x4_in  input  64 each  input state lanes
out_valid  output  1  result present, held until accepted
out_ready  input  1  consumer accepts result
x0_out..x4_out  output  64 each  result lanes, driven from state register
busy  output  1  high in RUN

Behaviour:
- Reset (async assert, sync release): state IDLE, state register 0, cnt 0, out_valid 0, busy 0; x*_out read 0.
- FSM IDLE / RUN / DONE. in_ready = (IDLE) | (DONE & out_ready).
- Accept edge (in_valid & in_ready): load lanes; cnt = min(in_rounds, MAX_ROUNDS); next = RUN if cnt != 0, else DONE.
- RUN, per edge: apply k = min(UNROLL, cnt) rounds; first round uses rcon = cnt, second (if k=2) uses rcon = cnt-1; cnt -= k; on cnt reaching 0 go to DONE.
- rcon = remaining-round count, giving constants 0xf0,0xe1,…,0x4b for p12, starting at 0xb4 for p8 and at 0x96 for p6.
- Odd round count with UNROLL=2: the final step bypasses the second instance. The state register takes the first-instance output.
- Latency, accept edge to out_valid high: ceil(N/UNROLL) edges, where N = the clamped count. N=0 gives out_valid high right after the accept edge, with lanes unchanged.
- DONE: out_valid=1, lanes stable.
  - out_ready=1 with no new request: go to IDLE.
  - out_ready=1 with in_valid=1 (same cycle): hand over and accept back-to-back; no bubble, and out_valid drops only if new N != 0.
- in_valid in RUN is ignored (in_ready=0). Inputs are sampled only on the accept edge.
- Reset asserted mid-RUN: immediate return to reset values. The partial result is discarded and no out_valid pulse is produced.
- cnt is 4-bit unsigned. The decrement never underflows because k <= cnt.

Decomposition:
- Shared package ascon_pkg:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - constants P12=4'd12, P8=4'd8, P6=4'd6, LANE_W=64
  - Ascon-Hash IV constant for tests
- Sub-module: reuse asconp unchanged (UNROLL instances in a generate loop). All sequencing lives in ascon_perm_ctrl.

Test Plan:
- p12 KAT, UNROLL=1:
  - Stimulus: x0=0x00400c0000000100, x1..x4=0, in_rounds=12.
  - Response: after 12 edges out_valid=1 with x0=ee9398aadb67f03d, x1=8bb21831c60f1002, x2=b48a92db98d5da62, x3=43189921b8f8e3e8, x4=348fa5c9d525e140.
- Same KAT with UNROLL=2 -> identical result after exactly 6 edges. busy is high for 6 cycles.
- p8 and p6 on random state -> match a software model that uses round constants starting at 0xb4 and 0x96. Latency is 8 / 6 edges (UNROLL=1); odd N=7 with UNROLL=2 takes 4 edges and matches the model.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid and lanes stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 -> in_ready=1 that cycle, and the next result follows with no idle cycle.
- Edge counts:
  - in_rounds=0 -> out_valid after 1 edge, lanes equal the input.
  - in_rounds=15 -> behaves as 12 (KAT result).
- Reset mid-RUN:
  - Drop reset_n after 5 rounds -> all outputs 0 asynchronously and state IDLE.
  - After release, a new p12 KAT request passes.
